sccb_master: RTL



---
 rtl/sccb_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sccb_master.sv
// sccb_master -- byte-level SCCB/I2C master for single-register accesses.
//
// Runs one register write or read per command, as received from the
// camera initializer over the ena/busy handshake.
//   write: START, addr|0, ACK, sub_addr, ACK, data_wr, ACK, STOP
//   read : START, addr|0, ACK, sub_addr, ACK, STOP,
//          RESTART, addr|1, ACK, 8 data bits, master NACK, STOP
// Each bit is four quarters of CLK_DIV clk cycles:
//   q0 SCL low with SDA update, q1..q3 SCL high, SDA sampled on the first cycle of q2.
//
// Ports: clk, rst (sync, active high); ena/rw/addr/sub_addr/data_wr = command;
//        data_rd/busy/done/ack_err = status; scl (push-pull), sda_oe (1 = pull
//        SDA low), sda_i (SDA line level).
//
// Build option: define SCCB_ACK_CHECK_EN to evaluate ACK slots. A NACK then sets
// ack_err and aborts to the final STOP. Without it, the ACK bit is a don't-care
// and ack_err stays 0.
module sccb_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] sub_addr,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, RX_ACK, STOP, RESTART, RX_BYTE, TX_NACK
  } state_t;

  state_t         state, state_nx;
  logic [QW-1:0]  qcnt;
  logic [1:0]     phase;
  logic [2:0]     bit_cnt;
  logic [1:0]     byte_sel;    // 0 addr|0, 1 sub_addr, 2 data_wr, 3 addr|1
  logic           rw_q;
  logic [7:0]     addr_q, sub_q, data_q;
  logic [7:0]     tx_sh, rx_sh;
  logic           final_stop;  // low only for the STOP between the two read phases
  logic           got_rx;
  logic           q_end, bit_end, smp_pt;
  logic           nack;

  assign q_end   = (qcnt == QW'(CLK_DIV - 1));
  assign bit_end = q_end && (phase == 2'd3);
  assign smp_pt  = (phase == 2'd2) && (qcnt == '0);
  assign busy    = (state != IDLE);

`ifdef SCCB_ACK_CHECK_EN
  logic ack_smp, ack_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_smp   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      if (state == RX_ACK && smp_pt) ack_smp <= sda_i;
      if (state == IDLE && ena)                       ack_err_q <= 1'b0;
      else if (state == RX_ACK && bit_end && ack_smp) ack_err_q <= 1'b1;
    end
  end

  assign nack    = ack_smp;
  assign ack_err = ack_err_q;
`else
  assign nack    = 1'b0;
  assign ack_err = 1'b0;
`endif

  // next state and completion pulse
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:           if (ena) state_nx = START;
      START, RESTART: if (bit_end) state_nx = TX_BYTE;
      TX_BYTE:        if (bit_end && bit_cnt == 3'd7) state_nx = RX_ACK;
      RX_ACK: begin
        if (bit_end) begin
          if (nack) state_nx = STOP;
          else begin
            case (byte_sel)
              2'd0:    state_nx = TX_BYTE;
              2'd1:    state_nx = rw_q ? STOP : TX_BYTE;
              2'd2:    state_nx = STOP;
              default: state_nx = RX_BYTE;
            endcase
          end
        end
      end
      RX_BYTE:        if (bit_end && bit_cnt == 3'd7) state_nx = TX_NACK;
      TX_NACK:        if (bit_end) state_nx = STOP;
      STOP: begin
        if (bit_end) begin
          if (final_stop) begin
            state_nx = IDLE;
            done     = 1'b1;
          end else begin
            state_nx = RESTART;
          end
        end
      end
      default:        state_nx = IDLE;
    endcase
  end

  // bus pins decoded from state and quarter
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      START, RESTART:           sda_oe = phase[1];
      TX_BYTE: begin
        scl    = (phase != 2'd0);
        sda_oe = ~tx_sh[7];
      end
      RX_ACK, RX_BYTE, TX_NACK: scl = (phase != 2'd0);
      STOP: begin
        scl    = (phase != 2'd0);
        sda_oe = ~phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      qcnt       <= '0;
      phase      <= 2'd0;
      bit_cnt    <= 3'd0;
      byte_sel   <= 2'd0;
      rw_q       <= 1'b0;
      addr_q     <= 8'h00;
      sub_q      <= 8'h00;
      data_q     <= 8'h00;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      data_rd    <= 8'h00;
      final_stop <= 1'b0;
      got_rx     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        qcnt    <= '0;
        phase   <= 2'd0;
        bit_cnt <= 3'd0;
        if (ena) begin
          rw_q       <= rw;
          addr_q     <= addr;
          sub_q      <= sub_addr;
          data_q     <= data_wr;
          final_stop <= 1'b0;
          got_rx     <= 1'b0;
        end
      end else begin
        qcnt <= q_end ? '0 : qcnt + 1'b1;
        if (q_end) phase <= phase + 2'd1;
      end

      if (bit_end) begin
        case (state)
          START: begin
            tx_sh    <= addr_q & 8'hFE;
            byte_sel <= 2'd0;
            bit_cnt  <= 3'd0;
          end
          RESTART: begin
            tx_sh    <= addr_q | 8'h01;
            byte_sel <= 2'd3;
            bit_cnt  <= 3'd0;
          end
          TX_BYTE: begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_ACK: begin
            bit_cnt <= 3'd0;
            if (state_nx == TX_BYTE) begin
              byte_sel <= byte_sel + 2'd1;
              tx_sh    <= (byte_sel == 2'd0) ? sub_q : data_q;
            end
            if (state_nx == STOP)
              final_stop <= nack || !rw_q || (byte_sel != 2'd1);
          end
          RX_BYTE: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) got_rx <= 1'b1;
          end
          TX_NACK: final_stop <= 1'b1;
          default: ;
        endcase
      end

      if (state == RX_BYTE && smp_pt) rx_sh <= {rx_sh[6:0], sda_i};

      // publish read data on the edge that opens the done cycle
      if (state == STOP && final_stop && got_rx && phase == 2'd3 &&
          qcnt == QW'(CLK_DIV - 2))
        data_rd <= rx_sh;
    end
  end

endmodule
